booth_divider: RTL



---
 rtl/booth_divider.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/booth_divider.sv
// booth_divider: sequential signed divider that produces one quotient bit per
// clock using non-restoring division on operand magnitudes.
// The quotient and remainder truncate toward zero, and the remainder takes the
// sign of the dividend. A divisor of zero takes a short path that reports the
// condition through div_by_zero.
module booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH:0]   r_p;          // signed partial remainder, one guard bit
    logic [WIDTH-1:0] r_q;          // dividend magnitude shifting into quotient
    logic [WIDTH-1:0] r_d;          // divisor magnitude
    logic [CW-1:0]    r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [WIDTH-1:0] r_dvd;        // raw dividend, reported on divide-by-zero
    logic             r_dbz_pend;   // DONE entered straight from IDLE, load results first

    logic             w_start_acc;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH:0]   w_d_ext;
    logic [WIDTH:0]   w_p_sh;
    logic [WIDTH:0]   w_p_step;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_q_signed;
    logic [WIDTH-1:0] w_r_signed;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_div_zero  = (divisor == {WIDTH{1'b0}});

    // Magnitudes are unsigned WIDTH-bit, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1).
    assign w_dvd_mag = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
    assign w_dsr_mag = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;

    // One non-restoring step. The sign of P before the shift selects subtract or add.
    // The guard bit is enough because P stays within [-2|D|, 2|D|) after the shift.
    assign w_d_ext  = {1'b0, r_d};
    assign w_p_sh   = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_p_step = r_p[WIDTH] ? (w_p_sh + w_d_ext) : (w_p_sh - w_d_ext);

    // Final restore. The corrected remainder lies in [0, |D|), so WIDTH bits hold it.
    assign w_rem_mag  = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d) : r_p[WIDTH-1:0];
    assign w_q_signed = r_q_neg ? ({WIDTH{1'b0}} - r_q) : r_q;
    assign w_r_signed = r_r_neg ? ({WIDTH{1'b0}} - w_rem_mag) : w_rem_mag;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A start pulse is honoured only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_div_zero ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_FIX;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (r_dbz_pend) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs: capture, iterate, fix signs, then strobe done.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_p         <= {(WIDTH+1){1'b0}};
            r_q         <= {WIDTH{1'b0}};
            r_d         <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dvd       <= {WIDTH{1'b0}};
            r_dbz_pend  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_p         <= {(WIDTH+1){1'b0}};
                        r_q         <= w_dvd_mag;
                        r_d         <= w_dsr_mag;
                        r_cnt       <= {CW{1'b0}};
                        r_q_neg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_r_neg     <= dividend[WIDTH-1];
                        r_dvd       <= dividend;
                        r_dbz_pend  <= w_div_zero;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        quotient    <= {WIDTH{1'b0}};
                        remainder   <= {WIDTH{1'b0}};
                        div_by_zero <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_p   <= w_p_step;
                    r_q   <= {r_q[WIDTH-2:0], ~w_p_step[WIDTH]};
                    r_cnt <= r_cnt + CNT_ONE;
                end
                S_FIX: begin
                    r_p       <= {1'b0, w_rem_mag};
                    quotient  <= w_q_signed;
                    remainder <= w_r_signed;
                    done      <= 1'b1;
                end
                S_DONE: begin
                    if (r_dbz_pend) begin
                        r_dbz_pend  <= 1'b0;
                        quotient    <= {WIDTH{1'b1}};
                        remainder   <= r_dvd;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        done <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
